// File: rtl/cricket_score_engine.sv
// Two-innings T20 scoring FSM feeding the seven-segment display stage.
// Optional free-hit rule is compiled in with the FREE_HIT_EN macro.
module cricket_score_engine #(
  parameter int OVERS          = 20,
  parameter int BALLS_PER_OVER = 6,
  parameter int MAX_WICKETS    = 10
) (
  input  logic       clk_fpga,
  input  logic       reset_n,
  input  logic       start,
  input  logic       ball_valid,
  input  logic [2:0] ball_runs,
  input  logic       ball_wicket,
  input  logic       ball_extra,
  output logic [7:0] binaryruns,
  output logic [3:0] binarywickets,
  output logic [7:0] balls_bowled,
  output logic [8:0] target,
  output logic       inningOver,
  output logic       gameOver,
  output logic       winner,
  output logic       tie
);

  // state | meaning
  // IDLE  | waiting for start, everything cleared
  // INN1  | team 1 batting
  // BREAK | innings break, target shown
  // INN2  | team 2 chasing
  // DONE  | result locked until start
  typedef enum logic [2:0] {IDLE, INN1, BREAK, INN2, DONE} state_t;

  localparam int BALL_LIMIT = OVERS * BALLS_PER_OVER;

  state_t     state;
  logic [8:0] run_sum;
  logic [7:0] runs_next;
  logic [7:0] balls_next;
  logic [3:0] wickets_next;
  logic       legal;
  logic       wk_hit;
  logic       inn_end;
  logic       chase;
  logic       level;
  logic       in_play;
  logic       innings_done;

`ifdef FREE_HIT_EN
  logic free_hit;
  assign wk_hit = legal & ball_wicket & ~free_hit;
`else
  assign wk_hit = legal & ball_wicket;
`endif

  always_comb begin
    legal        = ~ball_extra;
    run_sum      = {1'b0, binaryruns} + {8'd0, ball_extra} + {6'd0, ball_runs};
    runs_next    = run_sum[8] ? 8'hFF : run_sum[7:0];
    balls_next   = balls_bowled + {7'd0, legal};
    wickets_next = binarywickets + {3'd0, wk_hit};
    inn_end      = (wickets_next == 4'(MAX_WICKETS)) || (balls_next == 8'(BALL_LIMIT));
    chase        = {1'b0, runs_next} >= target;
    level        = ({1'b0, runs_next} + 9'd1) == target;
    in_play      = (state == INN1) || (state == INN2);
    innings_done = inn_end || ((state == INN2) && chase);
  end

`ifdef FREE_HIT_EN
  // An extra arms the free hit; the next legal ball consumes it.
  always_ff @(posedge clk_fpga or negedge reset_n) begin
    if (!reset_n)                                    free_hit <= 1'b0;
    else if (!in_play)                               free_hit <= 1'b0;
    else if (ball_valid && innings_done)             free_hit <= 1'b0;
    else if (ball_valid && !start)                   free_hit <= ball_extra;
    else if (ball_valid)                             free_hit <= ball_extra;
  end
`endif

  always_ff @(posedge clk_fpga or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      binaryruns    <= 8'd0;
      binarywickets <= 4'd0;
      balls_bowled  <= 8'd0;
      target        <= 9'd0;
      inningOver    <= 1'b0;
      gameOver      <= 1'b0;
      winner        <= 1'b0;
      tie           <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state         <= INN1;
          binaryruns    <= 8'd0;
          binarywickets <= 4'd0;
          balls_bowled  <= 8'd0;
          target        <= 9'd0;
        end
        INN1: if (ball_valid) begin
          binaryruns    <= runs_next;
          binarywickets <= wickets_next;
          balls_bowled  <= balls_next;
          if (inn_end) begin
            state      <= BREAK;
            inningOver <= 1'b1;
            target     <= {1'b0, runs_next} + 9'd1;
          end
        end
        BREAK: if (start) begin
          state         <= INN2;
          inningOver    <= 1'b0;
          binaryruns    <= 8'd0;
          binarywickets <= 4'd0;
          balls_bowled  <= 8'd0;
        end
        INN2: if (ball_valid) begin
          binaryruns    <= runs_next;
          binarywickets <= wickets_next;
          balls_bowled  <= balls_next;
          if (chase || inn_end) begin
            state    <= DONE;
            gameOver <= 1'b1;
            winner   <= chase;
            tie      <= ~chase & level;
          end
        end
        DONE: if (start) begin
          state         <= IDLE;
          binaryruns    <= 8'd0;
          binarywickets <= 4'd0;
          balls_bowled  <= 8'd0;
          target        <= 9'd0;
          gameOver      <= 1'b0;
          winner        <= 1'b0;
          tie           <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cricket_score_engine.sv
// Directed bench for cricket_score_engine: a one-over instance for match flow
// and a full twenty-over instance for all-out and saturation cases.
module tb_cricket_score_engine;

  logic       clk_fpga = 1'b0;
  logic       reset_n  = 1'b0;
  logic       start = 1'b0, ball_valid = 1'b0, ball_wicket = 1'b0, ball_extra = 1'b0;
  logic [2:0] ball_runs = 3'd0;

  logic [7:0] s_runs, l_runs, s_balls, l_balls;
  logic [3:0] s_wk, l_wk;
  logic [8:0] s_tgt, l_tgt;
  logic       s_inn, s_game, s_win, s_tie, l_inn, l_game, l_win, l_tie;
  logic [32:0] pack_s, pack_l;

  int total = 0;
  int bad   = 0;

`ifdef FREE_HIT_EN
  localparam int WK_FH = 0;
`else
  localparam int WK_FH = 1;
`endif

  always #5 clk_fpga = ~clk_fpga;

  cricket_score_engine #(.OVERS(1)) u_short (
    .clk_fpga(clk_fpga), .reset_n(reset_n), .start(start), .ball_valid(ball_valid),
    .ball_runs(ball_runs), .ball_wicket(ball_wicket), .ball_extra(ball_extra),
    .binaryruns(s_runs), .binarywickets(s_wk), .balls_bowled(s_balls), .target(s_tgt),
    .inningOver(s_inn), .gameOver(s_game), .winner(s_win), .tie(s_tie));

  cricket_score_engine #(.OVERS(20)) u_long (
    .clk_fpga(clk_fpga), .reset_n(reset_n), .start(start), .ball_valid(ball_valid),
    .ball_runs(ball_runs), .ball_wicket(ball_wicket), .ball_extra(ball_extra),
    .binaryruns(l_runs), .binarywickets(l_wk), .balls_bowled(l_balls), .target(l_tgt),
    .inningOver(l_inn), .gameOver(l_game), .winner(l_win), .tie(l_tie));

  assign pack_s = {s_runs, s_wk, s_balls, s_tgt, s_inn, s_game, s_win, s_tie};
  assign pack_l = {l_runs, l_wk, l_balls, l_tgt, l_inn, l_game, l_win, l_tie};

  typedef struct {
    logic        st;
    logic        v;
    logic [2:0]  r;
    logic        w;
    logic        x;
    logic [32:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [32:0] ex(input int r, wk, b, t, inn, game, win, tie);
    return {8'(r), 4'(wk), 8'(b), 9'(t), 1'(inn), 1'(game), 1'(win), 1'(tie)};
  endfunction

  task automatic add(input logic st, v, input int r, input logic w, x, input logic [32:0] e);
    vec_t t;
    t.st = st; t.v = v; t.r = 3'(r); t.w = w; t.x = x; t.exp = e;
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input logic [32:0] act, exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic st, v, input logic [2:0] r, input logic w, x);
    start = st; ball_valid = v; ball_runs = r; ball_wicket = w; ball_extra = x;
    @(posedge clk_fpga); #1;
    start = 1'b0; ball_valid = 1'b0; ball_runs = 3'd0; ball_wicket = 1'b0; ball_extra = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk_fpga); reset_n = 1'b0;
    @(negedge clk_fpga); reset_n = 1'b1;
  endtask

  initial begin
    // Game A: innings 1 of six singles, chase of 4 then 3
    add(1, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 1; k <= 5; k++) add(0, 1, 1, 0, 0, ex(k, 0, k, 0, 0, 0, 0, 0));
    add(0, 1, 1, 0, 0, ex(6, 0, 6, 7, 1, 0, 0, 0));
    add(0, 1, 4, 1, 0, ex(6, 0, 6, 7, 1, 0, 0, 0));
    add(1, 0, 0, 0, 0, ex(0, 0, 0, 7, 0, 0, 0, 0));
    add(0, 1, 4, 0, 0, ex(4, 0, 1, 7, 0, 0, 0, 0));
    add(0, 1, 3, 0, 0, ex(7, 0, 2, 7, 0, 1, 1, 0));
    add(0, 1, 2, 0, 0, ex(7, 0, 2, 7, 0, 1, 1, 0));
    add(1, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0, 0));
    // Game B: scores level at 6 -> tie
    add(1, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 1; k <= 5; k++) add(0, 1, 1, 0, 0, ex(k, 0, k, 0, 0, 0, 0, 0));
    add(0, 1, 1, 0, 0, ex(6, 0, 6, 7, 1, 0, 0, 0));
    add(1, 0, 0, 0, 0, ex(0, 0, 0, 7, 0, 0, 0, 0));
    for (int k = 1; k <= 5; k++) add(0, 1, 1, 0, 0, ex(k, 0, k, 7, 0, 0, 0, 0));
    add(0, 1, 1, 0, 0, ex(6, 0, 6, 7, 0, 1, 0, 1));
    add(1, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0, 0));
    // Game C: chase stalls at 5 -> team 1 wins
    add(1, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 1; k <= 6; k++) add(0, 1, 1, 0, 0, ex(k, 0, k, (k == 6) ? 7 : 0, (k == 6) ? 1 : 0, 0, 0, 0));
    add(1, 0, 0, 0, 0, ex(0, 0, 0, 7, 0, 0, 0, 0));
    for (int k = 1; k <= 5; k++) add(0, 1, 1, 0, 0, ex(k, 0, k, 7, 0, 0, 0, 0));
    add(0, 1, 0, 0, 0, ex(5, 0, 6, 7, 0, 1, 0, 0));
    add(1, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0, 0));
    // Game D: start beats ball in IDLE, extras, free hit, start ignored mid-innings
    add(1, 1, 4, 0, 0, ex(0, 0, 0, 0, 0, 0, 0, 0));
    add(0, 1, 4, 0, 1, ex(5, 0, 0, 0, 0, 0, 0, 0));
    add(0, 1, 0, 1, 1, ex(6, 0, 0, 0, 0, 0, 0, 0));
    add(0, 1, 0, 1, 0, ex(6, WK_FH, 1, 0, 0, 0, 0, 0));
    add(1, 1, 2, 0, 0, ex(8, WK_FH, 2, 0, 0, 0, 0, 0));
    add(0, 1, 1, 1, 0, ex(9, WK_FH + 1, 3, 0, 0, 0, 0, 0));

    @(posedge clk_fpga); #1;
    check("reset_short", pack_s, 33'd0);
    check("reset_long", pack_l, 33'd0);
    @(negedge clk_fpga); reset_n = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].st, vecs[i].v, vecs[i].r, vecs[i].w, vecs[i].x);
      check($sformatf("vec%0d", i), pack_s, vecs[i].exp);
    end

    // All out in innings 1 on the twenty-over instance
    do_reset();
    step(1, 0, 0, 0, 0);
    for (int k = 1; k <= 9; k++) step(0, 1, 0, 1, 0);
    check("nine_down", pack_l, ex(0, 9, 9, 0, 0, 0, 0, 0));
    step(0, 1, 0, 1, 0);
    check("all_out", pack_l, ex(0, 10, 10, 1, 1, 0, 0, 0));
    step(0, 1, 3, 1, 0);
    check("break_ignores_ball", pack_l, ex(0, 10, 10, 1, 1, 0, 0, 0));

    // Runs saturate at 255
    do_reset();
    step(1, 0, 0, 0, 0);
    for (int k = 0; k < 31; k++) step(0, 1, 7, 0, 1);
    check("extras_248", pack_l, ex(248, 0, 0, 0, 0, 0, 0, 0));
    step(0, 1, 2, 0, 0);
    check("runs_250", pack_l, ex(250, 0, 1, 0, 0, 0, 0, 0));
    step(0, 1, 6, 0, 0);
    check("runs_sat", pack_l, ex(255, 0, 2, 0, 0, 0, 0, 0));

    // Asynchronous reset in the middle of innings 2
    do_reset();
    step(1, 0, 0, 0, 0);
    for (int k = 0; k < 6; k++) step(0, 1, 1, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 1, 2, 0, 0);
    check("inn2_before_rst", pack_s, ex(2, 0, 1, 7, 0, 0, 0, 0));
    #2 reset_n = 1'b0;
    #1 check("async_rst_short", pack_s, 33'd0);
    check("async_rst_long", pack_l, 33'd0);
    @(negedge clk_fpga); reset_n = 1'b1;
    step(0, 1, 3, 0, 0);
    check("idle_after_rst", pack_s, 33'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
